dmem_sized: RTL and testbench

//  Parametrised data memory for the ARM-like core: 32-bit words, byte/half/word loads and stores
//  (LDRB/LDRH/LDR, STRB/STRH/STR) with byte-lane writes and zero-extended reads.

---
 rtl/dmem_pkg.sv | 68 ++++++
 rtl/dmem_lane_ram.sv | 30 +++
 rtl/dmem_sized.sv | 148 ++++++++++++++
 tb/tb_dmem_sized.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory: access sizes, FSM states,
// response record, and the lane decode/extract functions used by the top.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  // Reserved size or an address not naturally aligned to the access size.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lane);
    logic f;
    f = 1'b0;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = lane[0];
      SZ_WORD: f = (lane != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data across lanes; the lane mask picks the live copy.
  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] r;
    r = '0;
    case (size)
      SZ_BYTE: r = {24'b0, 8'(word >> {lane, 3'b000})};
      SZ_HALF: r = {16'b0, 16'(word >> {lane[1], 4'b0000})};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Single-port RAM of DEPTH words, each split into four byte lanes with independent
// write enables and a registered 32-bit read of the addressed word.
module dmem_lane_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [4][DEPTH];

  // NOTE: the array has no reset branch on purpose; a reset would turn it into flops.
  // Clearing is done one word per cycle by the owner's INIT state.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) mem[l][addr] <= wdata[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      rdata[8*l +: 8] <= mem[l][addr];
    end
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with valid/ready requests, fixed-latency in-order responses,
// alignment/range fault reporting and an optional post-reset clear sweep.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH);

  state_t        state;
  logic [AW-1:0] cnt;

  logic          accept;
  logic          fault;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  assign accept = req_valid & req_ready;
  assign fault  = size_fault(req_size, req_addr[1:0]) | (req_addr[31:AW+2] != '0);

  // The clear sweep owns the RAM port while in INIT; requests cannot be accepted then.
  always_comb begin
    ram_addr  = req_addr[AW+1:2];
    ram_we    = 4'b0000;
    ram_wdata = steer_wdata(req_size, req_wdata);
    if (!reset_n) begin
      ram_we = 4'b0000;
    end else if (state == ST_INIT) begin
      ram_addr  = cnt;
      ram_we    = 4'b1111;
      ram_wdata = '0;
    end else if (accept && req_we && !fault) begin
      ram_we = lane_mask(req_size, req_addr[1:0]);
    end
  end

  dmem_lane_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // First response stage: request attributes aligned with the RAM read register.
  logic       s1_valid;
  logic       s1_fault;
  logic       s1_load;
  logic [1:0] s1_size;
  logic [1:0] s1_lane;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_fault <= 1'b0;
      s1_load  <= 1'b0;
      s1_size  <= SZ_BYTE;
      s1_lane  <= 2'b00;
    end else begin
      s1_valid <= accept;
      s1_fault <= fault;
      s1_load  <= ~req_we;
      s1_size  <= req_size;
      s1_lane  <= req_addr[1:0];
    end
  end

  rsp_t rsp0;
  rsp_t rsp_out;

  // NOTE: every field gets a default before the conditionals, so no latch is inferred.
  always_comb begin
    rsp0       = '0;
    rsp0.valid = s1_valid;
    if (s1_valid) begin
      rsp0.fault = s1_fault;
      if (s1_load && !s1_fault) rsp0.rdata = load_extract(s1_size, s1_lane, ram_rdata);
    end
  end

  generate
    if (READ_LAT <= 1) begin : g_direct
      assign rsp_out = rsp0;
    end else begin : g_pipe
      rsp_t pipe [READ_LAT-1];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < READ_LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= rsp0;
          for (int i = 1; i < READ_LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign rsp_out = pipe[READ_LAT-2];
    end
  endgenerate

  assign rsp_valid = rsp_out.valid;
  assign rsp_rdata = rsp_out.rdata;
  assign rsp_fault = rsp_out.fault;

endmodule

// File: tb/tb_dmem_sized.sv
// Drives identical request streams into a READ_LAT=1 and a READ_LAT=3 instance and checks
// both against a byte-level memory model through per-instance response scoreboards.
module tb_dmem_sized;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_WORD;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        ready1, rsp_valid1, rsp_fault1, init_done1;
  logic [31:0] rsp_rdata1;
  logic        ready3, rsp_valid3, rsp_fault3, init_done3;
  logic [31:0] rsp_rdata3;

  dmem_sized #(.DEPTH(64), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_fault(rsp_fault1),
    .init_done(init_done1)
  );

  dmem_sized #(.DEPTH(64), .READ_LAT(3), .CLEAR_ON_RESET(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready3),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_fault(rsp_fault3),
    .init_done(init_done3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [7:0] model [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_rsp(input string name, input logic [31:0] rd, input logic ft, input exp_t e);
    check({name, " rdata"}, rd, e.rdata);
    check({name, " fault"}, 32'(ft), 32'(e.fault));
    check({name, " latency"}, cyc, e.due);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid1) begin
        if (q1.size() == 0) check("lat1 spurious rsp_valid", 32'(rsp_valid1), 32'd0);
        else cmp_rsp("lat1", rsp_rdata1, rsp_fault1, q1.pop_front());
      end else begin
        check("lat1 idle rdata", rsp_rdata1, 32'd0);
        check("lat1 idle fault", 32'(rsp_fault1), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid3) begin
        if (q3.size() == 0) check("lat3 spurious rsp_valid", 32'(rsp_valid3), 32'd0);
        else cmp_rsp("lat3", rsp_rdata3, rsp_fault3, q3.pop_front());
      end else begin
        check("lat3 idle rdata", rsp_rdata3, 32'd0);
        check("lat3 idle fault", 32'(rsp_fault3), 32'd0);
      end
    end
  end

  function automatic logic calc_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
           (a[31:2] >= 30'd64);
  endfunction

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int   n;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    e.fault = calc_fault(sz, a);
    e.rdata = '0;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (!e.fault) begin
      for (int i = 0; i < n; i++) begin
        if (we) model[int'(a[7:0]) + i] = wd[8*i +: 8];
        else    e.rdata[8*i +: 8] = model[int'(a[7:0]) + i];
      end
    end
    e.due = cyc + 1;
    q1.push_back(e);
    e.due = cyc + 3;
    q3.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Assert reset just after a negedge, then time the clear sweep. With hold set, a load of
  // word 0x20 is presented throughout INIT and only counted once req_ready is seen.
  task automatic do_reset(input bit hold);
    int n;
    #1;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    q1.delete();
    q3.delete();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("reset req_ready", {30'd0, ready3, ready1}, 32'd0);
    check("reset init_done", {30'd0, init_done3, init_done1}, 32'd0);
    check("reset rsp_valid", {30'd0, rsp_valid3, rsp_valid1}, 32'd0);
    reset_n = 1'b1;
    if (hold) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = SZ_WORD;
      req_addr  = 32'h20;
    end
    n = 0;
    while (ready1 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 32) check("init_done low mid-sweep", 32'(init_done1), 32'd0);
    end
    check("init cycles", n, 64);
    check("init_done after sweep", {30'd0, init_done3, init_done1}, 32'h3);
    check("lat3 ready with lat1", 32'(ready3), 32'(ready1));
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  initial begin
    do_reset(1'b0);
    issue(1'b0, SZ_WORD, 32'h00, 32'h0);

    // Sized stores with lane merging, then sized loads back-to-back.
    issue(1'b1, SZ_WORD, 32'h10, 32'h11223344);
    issue(1'b1, SZ_BYTE, 32'h11, 32'h123456AA);
    issue(1'b0, SZ_WORD, 32'h10, 32'h0);
    issue(1'b0, SZ_HALF, 32'h12, 32'h0);
    issue(1'b0, SZ_BYTE, 32'h11, 32'h0);
    issue(1'b1, SZ_HALF, 32'h16, 32'hFFFFBEEF);
    issue(1'b0, SZ_WORD, 32'h14, 32'h0);
    idle(2);

    // Faulting loads and stores; memory must stay unchanged.
    issue(1'b0, SZ_HALF, 32'h01, 32'h0);
    issue(1'b0, SZ_WORD, 32'h06, 32'h0);
    issue(1'b0, SZ_RSVD, 32'h00, 32'h0);
    issue(1'b0, SZ_WORD, 32'h100, 32'h0);
    issue(1'b1, SZ_HALF, 32'h11, 32'hFFFF);
    issue(1'b1, SZ_WORD, 32'h100, 32'hDEADBEEF);
    issue(1'b1, SZ_RSVD, 32'h10, 32'hDEADBEEF);
    issue(1'b1, SZ_WORD, 32'h12, 32'hDEADBEEF);
    issue(1'b1, SZ_WORD, 32'h80000010, 32'hDEADBEEF);
    issue(1'b0, SZ_WORD, 32'h10, 32'h0);
    issue(1'b0, SZ_WORD, 32'h00, 32'h0);

    // Store then load of the same word on consecutive cycles; top-of-range word.
    issue(1'b1, SZ_WORD, 32'h20, 32'hCAFEF00D);
    issue(1'b0, SZ_WORD, 32'h20, 32'h0);
    issue(1'b1, SZ_WORD, 32'hFC, 32'hA5A55A5A);
    issue(1'b0, SZ_BYTE, 32'hFF, 32'h0);
    issue(1'b0, SZ_HALF, 32'hFC, 32'h0);
    idle(6);

    // Reset with two loads in flight, valid held through INIT, then reread cleared data.
    issue(1'b1, SZ_WORD, 32'h24, 32'h00000055);
    issue(1'b0, SZ_WORD, 32'h20, 32'h0);
    issue(1'b0, SZ_WORD, 32'h24, 32'h0);
    do_reset(1'b1);
    issue(1'b0, SZ_WORD, 32'h20, 32'h0);
    issue(1'b0, SZ_WORD, 32'h24, 32'h0);
    issue(1'b0, SZ_WORD, 32'h10, 32'h0);
    idle(8);

    check("lat1 responses outstanding", q1.size(), 0);
    check("lat3 responses outstanding", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
